// File: rtl/pll_ce_pkg.sv
// Shared definitions for the PLL clock-enable generator.
//   pll_state_e : lock-qualification FSM states
//   *_DEF       : default divider / lock-wait constants
//   cnt_width() : counter width able to hold 0..n-1 (minimum 1 bit)
package pll_ce_pkg;

    typedef enum logic [1:0] {
        StWaitLock = 2'd0,
        StSettle   = 2'd1,
        StRun      = 2'd2
    } pll_state_e;

    localparam int unsigned DIV_6M_DEF      = 4;
    localparam int unsigned FRAC_NUM_DEF    = 5;
    localparam int unsigned FRAC_DEN_DEF    = 67;
    localparam int unsigned LOCK_WAIT_DEF   = 1024;
    localparam int unsigned SYNC_STAGES_DEF = 2;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pll_ce_gen_frac.sv
// Fractional clock-enable divider: NUM strobes every DEN enabled cycles, evenly spread.
// Ports:
//   i_clk : clock
//   i_clr : synchronous clear (accumulator to 0, strobe suppressed); has priority over i_en
//   i_en  : advance the accumulator this cycle
//   o_ce  : combinational strobe, high on the cycles whose accumulator step wraps;
//           the accumulator advances on the same edge, so register o_ce downstream
module frac_ce_div
    import pll_ce_pkg::*;
#(
    parameter int unsigned NUM = FRAC_NUM_DEF,
    parameter int unsigned DEN = FRAC_DEN_DEF
) (
    input  logic i_clk,
    input  logic i_clr,
    input  logic i_en,
    output logic o_ce
);

    // acc < DEN, so acc + NUM <= DEN + NUM - 1 always fits in this width.
    localparam int unsigned AccW = cnt_width(NUM + DEN);

    if (NUM >= DEN) begin : g_bad_ratio
        $fatal(1, "frac_ce_div: NUM (%0d) must be less than DEN (%0d)", NUM, DEN);
    end

    logic [AccW-1:0] r_acc;
    logic [AccW-1:0] w_sum;
    logic [AccW-1:0] w_acc_d;
    logic            w_wrap;

    always_comb begin
        w_sum   = r_acc + AccW'(NUM);
        w_wrap  = (w_sum >= AccW'(DEN));
        w_acc_d = w_wrap ? (w_sum - AccW'(DEN)) : w_sum;
        o_ce    = i_en & ~i_clr & w_wrap;
    end

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= w_acc_d;
        end
    end

endmodule

// File: rtl/pll_ce_gen.sv
// PLL consumer: lock qualification, core reset release and single-cycle clock enables,
// all in the clk_sys domain.
// Ports:
//   i_clk_sys         : 24 MHz system clock
//   i_reset           : synchronous active-high reset
//   i_pll_locked      : asynchronous PLL lock indication (synchronized internally)
//   o_core_reset      : active-high reset to core logic, low only in RUN
//   o_ce_6m           : one-cycle enable every DIV_6M RUN cycles
//   o_ce_1m79         : one-cycle enable, average rate FRAC_NUM/FRAC_DEN
//   o_ce_0m89         : every second o_ce_1m79 pulse
//   o_running         : high in RUN
//   o_lock_loss_cnt   : saturating count of lock losses seen in RUN
// Build option: define PLL_CE_LOCK_LOSS_CNT_EN to implement o_lock_loss_cnt; otherwise it is
// tied to zero.
module pll_ce_gen
    import pll_ce_pkg::*;
#(
    parameter int unsigned DIV_6M      = DIV_6M_DEF,
    parameter int unsigned FRAC_NUM    = FRAC_NUM_DEF,
    parameter int unsigned FRAC_DEN    = FRAC_DEN_DEF,
    parameter int unsigned LOCK_WAIT   = LOCK_WAIT_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic       i_clk_sys,
    input  logic       i_reset,
    input  logic       i_pll_locked,
    output logic       o_core_reset,
    output logic       o_ce_6m,
    output logic       o_ce_1m79,
    output logic       o_ce_0m89,
    output logic       o_running,
    output logic [7:0] o_lock_loss_cnt
);

    localparam int unsigned CntW = cnt_width(LOCK_WAIT);
    localparam int unsigned DivW = cnt_width(DIV_6M);

    if (FRAC_NUM >= FRAC_DEN) begin : g_bad_frac
        $fatal(1, "pll_ce_gen: FRAC_NUM (%0d) must be less than FRAC_DEN (%0d)",
               FRAC_NUM, FRAC_DEN);
    end
    if (DIV_6M < 2) begin : g_bad_div
        $fatal(1, "pll_ce_gen: DIV_6M (%0d) must be at least 2", DIV_6M);
    end
    if (LOCK_WAIT < 1 || SYNC_STAGES < 1) begin : g_bad_wait
        $fatal(1, "pll_ce_gen: LOCK_WAIT and SYNC_STAGES must be at least 1");
    end

    // ---------------- lock synchronizer ----------------
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_lk_s;

    always_ff @(posedge i_clk_sys) begin
        if (i_reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= SYNC_STAGES'({r_sync, i_pll_locked});
        end
    end

    assign w_lk_s = r_sync[SYNC_STAGES-1];

    // ---------------- FSM: state register ----------------
    pll_state_e      r_state;
    pll_state_e      w_state_d;
    logic [CntW-1:0] r_settle_cnt;
    logic [CntW-1:0] w_settle_cnt_d;

    always_ff @(posedge i_clk_sys) begin
        if (i_reset) begin
            r_state      <= StWaitLock;
            r_settle_cnt <= '0;
        end else begin
            r_state      <= w_state_d;
            r_settle_cnt <= w_settle_cnt_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_d      = r_state;
        w_settle_cnt_d = '0;
        unique case (r_state)
            StWaitLock: begin
                if (w_lk_s) w_state_d = StSettle;
            end
            StSettle: begin
                if (!w_lk_s) begin
                    w_state_d = StWaitLock;
                end else if (r_settle_cnt == CntW'(LOCK_WAIT - 1)) begin
                    w_state_d = StRun;
                end else begin
                    w_settle_cnt_d = r_settle_cnt + 1'b1;
                end
            end
            StRun: begin
                if (!w_lk_s) w_state_d = StWaitLock;
            end
            default: w_state_d = StWaitLock;
        endcase
    end

    // ---------------- FSM: outputs (next values, registered below) ----------------
    // Outputs are decoded from the next state so that they change on the same edge as the
    // state; enables therefore start from phase 0 on the first RUN cycle.
    logic            w_run_d;
    logic [DivW-1:0] r_div;
    logic [DivW-1:0] w_div_d;
    logic            w_ce_6m_d;
    logic            w_frac_ce;
    logic            r_tog;
    logic            w_tog_d;
    logic            w_ce_0m89_d;
    logic            w_lock_loss;

    always_comb begin
        w_run_d     = (w_state_d == StRun);
        w_ce_6m_d   = 1'b0;
        w_div_d     = '0;
        w_tog_d     = 1'b0;
        w_ce_0m89_d = 1'b0;
        if (w_run_d) begin
            w_ce_6m_d   = (r_div == DivW'(DIV_6M - 1));
            w_div_d     = w_ce_6m_d ? '0 : r_div + 1'b1;
            w_tog_d     = r_tog ^ w_frac_ce;
            w_ce_0m89_d = w_frac_ce & r_tog;
        end
        w_lock_loss = (r_state == StRun) && !w_lk_s;
    end

    frac_ce_div #(
        .NUM (FRAC_NUM),
        .DEN (FRAC_DEN)
    ) u_frac_1m79 (
        .i_clk (i_clk_sys),
        .i_clr (i_reset | ~w_run_d),
        .i_en  (w_run_d),
        .o_ce  (w_frac_ce)
    );

    logic r_core_reset;
    logic r_running;
    logic r_ce_6m;
    logic r_ce_1m79;
    logic r_ce_0m89;

    always_ff @(posedge i_clk_sys) begin
        if (i_reset) begin
            r_core_reset <= 1'b1;
            r_running    <= 1'b0;
            r_ce_6m      <= 1'b0;
            r_ce_1m79    <= 1'b0;
            r_ce_0m89    <= 1'b0;
            r_div        <= '0;
            r_tog        <= 1'b0;
        end else begin
            r_core_reset <= ~w_run_d;
            r_running    <= w_run_d;
            r_ce_6m      <= w_ce_6m_d;
            r_ce_1m79    <= w_frac_ce;
            r_ce_0m89    <= w_ce_0m89_d;
            r_div        <= w_div_d;
            r_tog        <= w_tog_d;
        end
    end

`ifdef PLL_CE_LOCK_LOSS_CNT_EN
    logic [7:0] r_lock_loss_cnt;

    // Reset has priority, so a loss coinciding with reset is not counted.
    always_ff @(posedge i_clk_sys) begin
        if (i_reset) begin
            r_lock_loss_cnt <= 8'd0;
        end else if (w_lock_loss && (r_lock_loss_cnt != 8'hFF)) begin
            r_lock_loss_cnt <= r_lock_loss_cnt + 8'd1;
        end
    end

    assign o_lock_loss_cnt = r_lock_loss_cnt;
`else
    logic w_unused_loss;
    assign w_unused_loss   = w_lock_loss;
    assign o_lock_loss_cnt = 8'd0;
`endif

    assign o_core_reset = r_core_reset;
    assign o_running    = r_running;
    assign o_ce_6m      = r_ce_6m;
    assign o_ce_1m79    = r_ce_1m79;
    assign o_ce_0m89    = r_ce_0m89;

endmodule

// File: tb/tb_pll_ce_gen.sv
// Self-checking bench for pll_ce_gen: default-parameter DUT checked every cycle against a
// streak/arithmetic reference model, plus a short-LOCK_WAIT DUT for counter saturation.
module tb_pll_ce_gen;

    localparam int LW  = 1024;
    localparam int SS  = 2;
    localparam int DIV = 4;
    localparam int NUM = 5;
    localparam int DEN = 67;
    localparam int LW2 = 8;
    localparam int REL = SS + LW + 1;

`ifdef PLL_CE_LOCK_LOSS_CNT_EN
    localparam bit LossEn = 1'b1;
`else
    localparam bit LossEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pin = 1'b1;
    logic       pin2 = 1'b0;
    logic       core_reset, ce_6m, ce_1m79, ce_0m89, running;
    logic [7:0] loss_cnt;
    logic       core_reset2, ce_6m2, ce_1m792, ce_0m892, running2;
    logic [7:0] loss_cnt2;

    always #5 clk = ~clk;

    pll_ce_gen u_dut (
        .i_clk_sys       (clk),
        .i_reset         (rst),
        .i_pll_locked    (pin),
        .o_core_reset    (core_reset),
        .o_ce_6m         (ce_6m),
        .o_ce_1m79       (ce_1m79),
        .o_ce_0m89       (ce_0m89),
        .o_running       (running),
        .o_lock_loss_cnt (loss_cnt)
    );

    pll_ce_gen #(
        .LOCK_WAIT (LW2)
    ) u_dut_sat (
        .i_clk_sys       (clk),
        .i_reset         (rst),
        .i_pll_locked    (pin2),
        .o_core_reset    (core_reset2),
        .o_ce_6m         (ce_6m2),
        .o_ce_1m79       (ce_1m792),
        .o_ce_0m89       (ce_0m892),
        .o_running       (running2),
        .o_lock_loss_cnt (loss_cnt2)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: RUN holds once lk_s has been sampled high on LW+1 consecutive edges.
    int m_sync[SS];
    int m_streak = 0;
    int m_runn   = 0;
    int m_losses = 0;

    function automatic void model_edge(input logic r, input logic p);
        int lk;
        if (r) begin
            foreach (m_sync[i]) m_sync[i] = 0;
            m_streak = 0;
            m_runn   = 0;
            m_losses = 0;
        end else begin
            lk = m_sync[SS-1];
            for (int i = SS - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
            m_sync[0] = int'(p);
            if (lk != 0) begin
                m_streak++;
            end else begin
                if (m_streak >= LW + 1 && m_losses < 255) m_losses++;
                m_streak = 0;
            end
            if (m_streak >= LW + 1) m_runn++;
            else m_runn = 0;
        end
    endfunction

    function automatic logic [12:0] model_out();
        logic run, e6, e179, e089;
        int   n, k, kp, cnt;
        n    = m_runn;
        run  = (m_streak >= LW + 1);
        e6   = (n > 0) && (n % DIV == 0);
        k    = (NUM * n) / DEN;
        kp   = (n > 0) ? (NUM * (n - 1)) / DEN : 0;
        e179 = (n > 0) && (k != kp);
        e089 = e179 && (k % 2 == 0);
        cnt  = LossEn ? m_losses : 0;
        return {~run, run, e6, e179, e089, cnt[7:0]};
    endfunction

    task automatic step(input logic r, input logic p);
        rst = r;
        pin = p;
        @(posedge clk);
        model_edge(r, p);
        @(negedge clk);
        check("cycle", 32'({core_reset, running, ce_6m, ce_1m79, ce_0m89, loss_cnt}),
              32'(model_out()));
    endtask

    // Holds pin high and counts cycles until core_reset drops (bounded).
    task automatic release_wait(input string tag);
        int cyc;
        cyc = 0;
        do begin
            step(1'b0, 1'b1);
            cyc++;
        end while (core_reset && cyc < REL + 200);
        check(tag, 32'(cyc), 32'(REL));
        check({tag, "_running"}, 32'(running), 32'd1);
    endtask

    initial begin
        int c6, c179, c089, last, gmin, gmax, n, hi, lo;

        foreach (m_sync[i]) m_sync[i] = 0;

        // Reset with lock already high.
        repeat (3) step(1'b1, 1'b1);
        check("rst_core_reset", 32'(core_reset), 32'd1);
        check("rst_running", 32'(running), 32'd0);
        check("rst_ce", 32'({ce_6m, ce_1m79, ce_0m89}), 32'd0);
        check("rst_loss_cnt", 32'(loss_cnt), 32'd0);
        check("rst_sat_core_reset", 32'(core_reset2), 32'd1);

        release_wait("release_lat");

        // 6700 RUN cycles: rates and ce_1m79 spacing.
        c6 = 0; c179 = 0; c089 = 0; last = -1; gmin = 1000; gmax = 0;
        for (int i = 2; i <= 6700; i++) begin
            step(1'b0, 1'b1);
            c6   += int'(ce_6m);
            c089 += int'(ce_0m89);
            if (ce_1m79) begin
                c179++;
                if (last > 0) begin
                    if (i - last < gmin) gmin = i - last;
                    if (i - last > gmax) gmax = i - last;
                end
                last = i;
            end
        end
        check("cnt_ce_6m", 32'(c6), 32'd1675);
        check("cnt_ce_1m79", 32'(c179), 32'd500);
        check("cnt_ce_0m89", 32'(c089), 32'd250);
        check("gap_max", 32'(gmax), 32'd14);
        check("gap_min", 32'(gmin), 32'd13);

        // Lock loss in RUN: core_reset returns two edges after the pin drops.
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("loss_hold_core_reset", 32'(core_reset), 32'd0);
        step(1'b0, 1'b0);
        check("loss_core_reset", 32'(core_reset), 32'd1);
        check("loss_ce", 32'({ce_6m, ce_1m79, ce_0m89}), 32'd0);
        check("loss_cnt_1", 32'(loss_cnt), LossEn ? 32'd1 : 32'd0);
        release_wait("relock_lat");

        // One-cycle dropout mid-SETTLE restarts the wait.
        repeat (5) step(1'b0, 1'b0);
        repeat (501) step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        release_wait("settle_restart_lat");

        // Reset pulse mid-RUN.
        repeat (10) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        check("midrst_core_reset", 32'(core_reset), 32'd1);
        check("midrst_running", 32'(running), 32'd0);
        check("midrst_ce", 32'({ce_6m, ce_1m79, ce_0m89}), 32'd0);
        check("midrst_loss_cnt", 32'(loss_cnt), 32'd0);
        release_wait("midrst_lat");
        n = 1;
        while (!ce_6m && n < 20) begin
            step(1'b0, 1'b1);
            n++;
        end
        check("midrst_first_ce6m", 32'(n), 32'd4);

        // Randomized lock/reset activity against the model.
        for (int seg = 0; seg < 14; seg++) begin
            if ($urandom_range(0, 4) == 0) begin
                repeat ($urandom_range(1, 3)) step(1'b1, 1'($urandom_range(0, 1)));
            end
            hi = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 40) : $urandom_range(1030, 1150);
            lo = $urandom_range(1, 6);
            repeat (hi) step(1'b0, 1'b1);
            repeat (lo) step(1'b0, 1'b0);
        end

        // Saturation on the short-wait instance; the main DUT is re-released meanwhile.
        for (int it = 1; it <= 300; it++) begin
            pin2 = 1'b1;
            repeat (14) step(1'b0, 1'b1);
            if (it == 1) check("sat_running", 32'(running2), 32'd1);
            pin2 = 1'b0;
            repeat (3) step(1'b0, 1'b1);
            if (it == 100) check("sat_cnt_100", 32'(loss_cnt2), LossEn ? 32'd100 : 32'd0);
        end
        check("sat_cnt_300", 32'(loss_cnt2), LossEn ? 32'd255 : 32'd0);
        check("sat_core_reset", 32'(core_reset2), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pll_ce_gen.md
Name: pll_ce_gen

Overview:
- Consumer end of the video/audio PLL outputs. Runs entirely in the 24 MHz system clock domain.
- Replaces the PLL's slow output clocks (6 MHz, 1.791044 MHz, 0.895522 MHz) with single-cycle clock enables, so downstream logic stays single-clock.
- Qualifies the PLL `locked` signal and owns the core reset release, keeping the CPU, sound and video blocks in reset until the clock is stable.

Parameters:
- DIV_6M, 4, integer divide of clk_sys for ce_6m
- FRAC_NUM, 5, fractional accumulator increment for ce_1m79 (24 MHz × 5/67 = 1.791044 MHz)
- FRAC_DEN, 67, fractional accumulator modulus
- LOCK_WAIT, 1024, clk_sys cycles `locked` must stay high before reset release
- SYNC_STAGES, 2, synchronizer depth for pll_locked

Ports:
- clk_sys, in, 1, 24 MHz system clock
- reset, in, 1, synchronous active-high reset
- pll_locked, in, 1, asynchronous PLL lock indication
- core_reset, out, 1, synchronous active-high reset to core logic
- ce_6m, out, 1, one-cycle enable at clk_sys/DIV_6M
- ce_1m79, out, 1, one-cycle enable, average rate clk_sys × FRAC_NUM/FRAC_DEN
- ce_0m89, out, 1, one-cycle enable on every second ce_1m79
- running, out, 1, high in RUN state
- lock_loss_cnt, out, 8, saturating count of lock losses seen in RUN

Behaviour:
- Reset values: core_reset=1, all ce_*=0, running=0, lock_loss_cnt=0, accumulator=0, dividers=0, state=WAIT_LOCK.
- pll_locked passes through a SYNC_STAGES-deep flop chain → lk_s. All decisions use lk_s, which lags the pin by SYNC_STAGES cycles.
- State machine:
  - WAIT_LOCK: core_reset=1; settle counter held at 0. If lk_s=1, go to SETTLE.
  - SETTLE: counter increments each cycle.
    - If lk_s=0: counter clears, go to WAIT_LOCK.
    - If counter reaches LOCK_WAIT-1: go to RUN.
  - RUN: core_reset=0, running=1, enables active.
    - If lk_s=0: go to WAIT_LOCK. core_reset reasserts the cycle after lk_s falls.
    - lock_loss_cnt increments by 1, saturating at 255.
- Release latency: core_reset first deasserts exactly LOCK_WAIT+1 cycles after lk_s rises, provided lk_s stays high.
- All outputs are registered.
- Enable generation runs only in RUN. Outside RUN, dividers and accumulator are held at 0 and all ce_*=0. The first cycle of RUN therefore starts from phase 0.
- ce_6m: mod-DIV_6M counter. Pulses on cycles where count==DIV_6M-1, i.e. the first pulse occurs on the 4th RUN cycle.
- ce_1m79:
  - Accumulator is ceil(log2(FRAC_DEN+FRAC_NUM)) bits wide.
  - Each RUN cycle compute sum = acc + FRAC_NUM.
  - If sum ≥ FRAC_DEN: acc ← sum − FRAC_DEN and pulse ce_1m79.
  - Otherwise: acc ← sum, no pulse.
  - Gives exactly FRAC_NUM pulses per FRAC_DEN cycles. Spacing is 13 or 14 cycles and never 2 consecutive.
- ce_0m89: toggle flop advanced on each ce_1m79. ce_0m89 pulses together with ce_1m79 when the toggle is 1, starting with the second ce_1m79.
- Simultaneous events:
  - pll reset and lock loss in the same cycle: reset wins; lock_loss_cnt is cleared, not incremented.
  - ce_6m and ce_1m79 coinciding is legal; both pulse.
- Reset mid-operation returns to the reset values on the next edge, regardless of state.
- Static constraints: FRAC_NUM < FRAC_DEN and DIV_6M ≥ 2. Violations are caught by an elaboration-time check that emits a fatal message.

Optional Feature:
- Macro: PLL_CE_LOCK_LOSS_CNT_EN.
- Defined: lock_loss_cnt implemented as above.
- Undefined: counter logic removed; lock_loss_cnt tied to 8'd0. All other behaviour is identical.

Decomposition:
- Shared package pll_ce_pkg holds:
  - state enum (WAIT_LOCK, SETTLE, RUN)
  - default constants DIV_6M_DEF=4, FRAC_NUM_DEF=5, FRAC_DEN_DEF=67, LOCK_WAIT_DEF=1024
- Natural sub-module: frac_ce_div. It takes parameters NUM/DEN and ports clk, clr, en, ce. It is instantiated for ce_1m79 and is reusable for other fractional rates.

Test Plan:
- pll_locked=1 held from reset deassert → core_reset falls exactly SYNC_STAGES+LOCK_WAIT+1 cycles later (1027 with defaults); running=1 on the same cycle.
- 6700 RUN cycles → ce_6m=1675 pulses, ce_1m79=500, ce_0m89=250; max gap between ce_1m79 pulses is 14, min gap 13.
- pll_locked drops for 1 cycle during SETTLE at count 500 → counter restarts; release happens 1024+1 cycles after lk_s returns high.
- pll_locked drops in RUN → core_reset=1 and all ce_*=0 from the cycle after lk_s falls; lock_loss_cnt 0→1; relock gives a fresh 1025-cycle wait.
- 300 lock-loss/relock cycles → lock_loss_cnt saturates at 255. With PLL_CE_LOCK_LOSS_CNT_EN undefined it stays 0.
- reset asserted mid-RUN for 1 cycle → the next cycle matches all reset values; the enable phase restarts so that ce_6m first pulses on the 4th RUN cycle after re-release.
